// File: rtl/frame_dma_writer_if.sv
// frame_dma_writer_if: pixel input stream plus Avalon-MM write-master bus
// for frame_dma_writer. The master modport is the DMA's view. The slave
// modport is the view of the capture FIFO and fabric that surround it.
interface frame_dma_writer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_waitrequest;
    logic [DATA_W-1:0]   din;
    logic                din_valid;
    logic                din_ready;

    modport master (
        output avm_address,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        input  avm_waitrequest,
        input  din,
        input  din_valid,
        output din_ready
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        output avm_waitrequest,
        output din,
        output din_valid,
        input  din_ready
    );
endinterface

// File: rtl/frame_dma_writer.sv
// frame_dma_writer: Avalon-MM write master. It moves one frame of pixels from
// the capture FIFO into memory. Each pixel becomes one single-beat write at
// base_addr + i*(DATA_W/8). Software arms the block with start and polls
// busy/done. abort ends the frame early.
//
// Handshakes:
//   A pixel is consumed on a rising edge where din_valid && din_ready && !abort.
//   din_ready is high only in FILL. An abort in FILL therefore leaves the
//   presented pixel unconsumed, even though din_ready was high.
//   A write is accepted on a rising edge where avm_write && !avm_waitrequest.
//   While the write waits, address, data and byteenable stay frozen, and the
//   request is never withdrawn.
module frame_dma_writer #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16,
    parameter int FRAME_PIXELS = 307200,
    parameter int CNT_W        = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  base_addr,
    frame_dma_writer_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [CNT_W-1:0]   pixels_written,
    output logic [1:0]         state_dbg
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_PIXELS - 1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    count_q;
    logic                abort_flag;
    logic                aborted_q;
    logic                start_ok;
    logic                wr_accept;
    logic                abort_end;

    assign start_ok  = (state == IDLE) && start && !abort;
    assign wr_accept = (state == WRITE) && !bus.avm_waitrequest;
    // The frame ends by abort either in FILL, where nothing is pending, or at
    // the acceptance of the write that was in flight when abort arrived.
    assign abort_end = ((state == FILL) && abort) ||
                       (wr_accept && (abort_flag || abort));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_next    = state;
        busy          = 1'b0;
        done          = 1'b0;
        bus.din_ready = 1'b0;
        bus.avm_write = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) state_next = FILL;
            end
            FILL: begin
                busy          = 1'b1;
                bus.din_ready = 1'b1;
                if (abort)              state_next = IDLE;
                else if (bus.din_valid) state_next = WRITE;
            end
            WRITE: begin
                busy          = 1'b1;
                bus.avm_write = 1'b1;
                if (wr_accept) begin
                    if (abort_flag || abort)    state_next = IDLE;
                    else if (count_q == LAST_IDX) state_next = FINISH;
                    else                          state_next = FILL;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address, data, pixel count and the abort bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
            abort_flag <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            aborted_q <= abort_end;
            if (start_ok) begin
                addr_q     <= base_addr;
                count_q    <= '0;
                abort_flag <= 1'b0;
            end
            if ((state == FILL) && bus.din_valid && !abort) begin
                wdata_q <= bus.din;
            end
            if ((state == WRITE) && abort) begin
                abort_flag <= 1'b1;
            end
            if (wr_accept) begin
                addr_q  <= addr_q + ADDR_STEP;
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.avm_address    = addr_q;
    assign bus.avm_writedata  = wdata_q;
    assign bus.avm_byteenable = '1;
    assign aborted            = aborted_q;
    assign pixels_written     = count_q;
    assign state_dbg          = state;
endmodule
